// File: rtl/alu_cmp_pkg.sv
// -----------------------------------------------------------------------------
// alu_cmp_pkg
// Shared definitions for the iterative magnitude comparator (alu_cmp_iter):
//   cmp_op_e      operation codes seen on in_op
//   cmp_state_e   controller states
//   is_signed_op  ops that compare as two's-complement
//   is_legal_op   ops the comparator understands (anything else -> out_err)
// -----------------------------------------------------------------------------
package alu_cmp_pkg;

   typedef enum logic [4:0] {
      OP_BEQ  = 5'd0,
      OP_BNE  = 5'd1,
      OP_BLT  = 5'd2,
      OP_BGE  = 5'd3,
      OP_BLTU = 5'd4,
      OP_BGEU = 5'd5,
      OP_SLT  = 5'd9,
      OP_SLTU = 5'd10,
      OP_MIN  = 5'd11,
      OP_MAX  = 5'd12,
      OP_MINU = 5'd13,
      OP_MAXU = 5'd14
   } cmp_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } cmp_state_e;

   function automatic logic is_signed_op(input logic [4:0] op);
      case (op)
         OP_BLT, OP_BGE, OP_SLT, OP_MIN, OP_MAX: is_signed_op = 1'b1;
         default:                                is_signed_op = 1'b0;
      endcase
   endfunction

   function automatic logic is_legal_op(input logic [4:0] op);
      case (op)
         OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
         OP_SLT, OP_SLTU, OP_MIN, OP_MAX, OP_MINU, OP_MAXU: is_legal_op = 1'b1;
         default:                                           is_legal_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_cmp_iter_chunk.sv
// -----------------------------------------------------------------------------
// cmp_chunk
// Purely combinational unsigned compare of one CHUNK-bit slice.
// Ports:
//   a, b  in   CHUNK   slice of operand A / operand B
//   eq    out  1       a == b
//   lt    out  1       a <  b (unsigned)
// -----------------------------------------------------------------------------
module cmp_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   output logic             eq,
   output logic             lt
);

   assign eq = (a == b);
   assign lt = (a < b);

endmodule

// File: rtl/alu_cmp_iter.sv
// -----------------------------------------------------------------------------
// alu_cmp_iter
// Iterative magnitude comparator for branch conditions, SLT/SLTU and
// MIN/MAX/MINU/MAXU. Compares CHUNK bits per cycle from the MSB down and stops
// at the first differing chunk. Valid/ready handshake on both sides.
// Ports:
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous active-high reset
//   in_valid     in   1      request present
//   in_ready     out  1      high in IDLE only
//   in_op        in   5      operation code (cmp_op_e)
//   in_dat1      in   WIDTH  operand A
//   in_dat2      in   WIDTH  operand B
//   out_valid    out  1      result held (DONE)
//   out_ready    in   1      consumer takes result
//   out_con_met  out  1      branch condition true (branch ops only)
//   out_result   out  WIDTH  SLT/SLTU 0/1, MIN/MAX selected operand, else 0
//   out_err      out  1      op code not recognised
// -----------------------------------------------------------------------------
module alu_cmp_iter
   import alu_cmp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_op,
   input  logic [WIDTH-1:0] in_dat1,
   input  logic [WIDTH-1:0] in_dat2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_con_met,
   output logic [WIDTH-1:0] out_result,
   output logic             out_err
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [KW-1:0]    K_TOP = KW'(NCHUNK - 1);
   localparam logic [WIDTH-1:0] MSB   = WIDTH'(1) << (WIDTH - 1);

   if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
      $error("alu_cmp_iter: CHUNK must be in 1..WIDTH and divide WIDTH");
   end

   cmp_state_e       state;
   logic [KW-1:0]    k;
   logic [4:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             sgn_q;

   logic [WIDTH-1:0] a_cmp;
   logic [WIDTH-1:0] b_cmp;
   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic             c_eq;
   logic             c_lt;
   logic             legal;
   logic             done_now;
   logic             lt_fin;
   logic             con_n;
   logic [WIDTH-1:0] res_n;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // Flipping the sign bit of both operands maps two's-complement order onto
   // unsigned order, so one unsigned chunk comparator serves every op. The
   // stored operands stay untouched because MIN/MAX return them verbatim.
   assign a_cmp = a_q ^ (sgn_q ? MSB : '0);
   assign b_cmp = b_q ^ (sgn_q ? MSB : '0);

   always_comb begin
      a_chunk = a_cmp[int'(k)*CHUNK +: CHUNK];
      b_chunk = b_cmp[int'(k)*CHUNK +: CHUNK];
   end

   cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a  (a_chunk),
      .b  (b_chunk),
      .eq (c_eq),
      .lt (c_lt)
   );

   assign legal = is_legal_op(op_q);

   // An illegal op finishes after its first RUN cycle; a legal one finishes at
   // the first differing chunk or after the last (lowest) chunk.
   assign done_now = !legal || !c_eq || (k == '0);
   assign lt_fin   = !c_eq && c_lt;

   always_comb begin
      con_n = 1'b0;
      res_n = '0;
      case (op_q)
         OP_BEQ:           con_n = c_eq;
         OP_BNE:           con_n = !c_eq;
         OP_BLT, OP_BLTU:  con_n = lt_fin;
         OP_BGE, OP_BGEU:  con_n = !lt_fin;
         OP_SLT, OP_SLTU:  res_n = WIDTH'(lt_fin);
         OP_MIN, OP_MINU:  res_n = lt_fin ? a_q : b_q;
         OP_MAX, OP_MAXU:  res_n = lt_fin ? b_q : a_q;
         default: ;
      endcase
   end

   // Request payload: captured on accept, held through RUN and DONE.
   always_ff @(posedge clk) begin
      if ((state == IDLE) && in_valid) begin
         op_q  <= in_op;
         a_q   <= in_dat1;
         b_q   <= in_dat2;
         sgn_q <= is_signed_op(in_op);
      end
   end

   // Controller and registered results.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         k           <= '0;
         out_con_met <= 1'b0;
         out_result  <= '0;
         out_err     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  k     <= K_TOP;
                  state <= RUN;
               end
            end
            RUN: begin
               if (done_now) begin
                  out_con_met <= con_n;
                  out_result  <= res_n;
                  out_err     <= !legal;
                  state       <= DONE;
               end else begin
                  k <= k - KW'(1);
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_cmp_iter.sv
module tb_alu_cmp_iter;

   localparam int NI = 4;
   localparam int CH[NI] = '{8, 1, 4, 32};

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid [NI];
   logic        in_ready [NI];
   logic [4:0]  in_op    [NI];
   logic [31:0] dat1     [NI];
   logic [31:0] dat2     [NI];
   logic        out_valid[NI];
   logic        out_ready[NI];
   logic        con_met  [NI];
   logic [31:0] result   [NI];
   logic        err      [NI];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_cmp_iter #(.WIDTH(32), .CHUNK(8)) u_c8 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_op(in_op[0]), .in_dat1(dat1[0]), .in_dat2(dat2[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_con_met(con_met[0]), .out_result(result[0]), .out_err(err[0]));

   alu_cmp_iter #(.WIDTH(32), .CHUNK(1)) u_c1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_op(in_op[1]), .in_dat1(dat1[1]), .in_dat2(dat2[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_con_met(con_met[1]), .out_result(result[1]), .out_err(err[1]));

   alu_cmp_iter #(.WIDTH(32), .CHUNK(4)) u_c4 (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_op(in_op[2]), .in_dat1(dat1[2]), .in_dat2(dat2[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .out_con_met(con_met[2]), .out_result(result[2]), .out_err(err[2]));

   alu_cmp_iter #(.WIDTH(32), .CHUNK(32)) u_c32 (
      .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
      .in_op(in_op[3]), .in_dat1(dat1[3]), .in_dat2(dat2[3]),
      .out_valid(out_valid[3]), .out_ready(out_ready[3]),
      .out_con_met(con_met[3]), .out_result(result[3]), .out_err(err[3]));

   // Reference model: plain signed/unsigned arithmetic; latency is the number
   // of chunks scanned from the top down to the highest differing bit.
   function automatic void model(input int ch, input logic [4:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic con, output logic [31:0] res,
                                 output logic er, output int lat);
      logic        lt_s, lt_u, eq;
      logic [31:0] d;
      int          p;
      lt_s = ($signed(a) < $signed(b));
      lt_u = (a < b);
      eq   = (a == b);
      con  = 1'b0;
      res  = 32'd0;
      er   = 1'b0;
      d    = a ^ b;
      if (d == 32'd0) begin
         lat = 32 / ch;
      end else begin
         p = 31;
         while (!d[p]) p--;
         lat = 32 / ch - p / ch;
      end
      case (op)
         5'd0:  con = eq;
         5'd1:  con = !eq;
         5'd2:  con = lt_s;
         5'd3:  con = !lt_s;
         5'd4:  con = lt_u;
         5'd5:  con = !lt_u;
         5'd9:  res = {31'd0, lt_s};
         5'd10: res = {31'd0, lt_u};
         5'd11: res = lt_s ? a : b;
         5'd12: res = lt_s ? b : a;
         5'd13: res = lt_u ? a : b;
         5'd14: res = lt_u ? b : a;
         default: begin er = 1'b1; lat = 1; end
      endcase
   endfunction

   // Issue one op on instance i, scramble the inputs while it runs, collect
   // the result and its latency (edges after the accept edge), then consume.
   task automatic run_op(input int i, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic con,
                         output logic [31:0] res, output logic er);
      @(negedge clk);
      in_op[i] = op; dat1[i] = a; dat2[i] = b; in_valid[i] = 1'b1;
      @(negedge clk);
      in_valid[i] = 1'b0;
      in_op[i] = 5'($urandom); dat1[i] = $urandom; dat2[i] = $urandom;
      lat = 0;
      while (!out_valid[i] && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      con = con_met[i]; res = result[i]; er = err[i];
      out_ready[i] = 1'b1;
      @(negedge clk);
      out_ready[i] = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      for (int i = 0; i < NI; i++) begin
         in_valid[i] = 1'b0; out_ready[i] = 1'b0; in_op[i] = 5'd0;
         dat1[i] = 32'd0; dat2[i] = 32'd0;
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (out_valid[i] !== 1'b0 || con_met[i] !== 1'b0 || result[i] !== 32'd0 || err[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs inst=%0d got v=%b c=%b r=%h e=%b want all zero",
                     i, out_valid[i], con_met[i], result[i], err[i]);
         end
      end
      rst = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (in_ready[i] !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready inst=%0d got %b want 1", i, in_ready[i]);
         end
      end
   endtask

   task automatic test_directed;
      logic [4:0]  t_op [8];
      logic [31:0] t_a  [8];
      logic [31:0] t_b  [8];
      logic        t_con[8];
      logic [31:0] t_res[8];
      int          t_lat[8];
      int          lat;
      logic        con, er;
      logic [31:0] res;
      t_op = '{5'd2, 5'd4, 5'd0, 5'd4, 5'd12, 5'd14, 5'd9, 5'd10};
      t_a  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h100,
               32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
      t_b  = '{32'h1, 32'h1, 32'h12345678, 32'h101,
               32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
      t_con = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      t_res = '{32'd0, 32'd0, 32'd0, 32'd0, 32'h7FFFFFFF, 32'h80000000, 32'd1, 32'd0};
      t_lat = '{1, 1, 4, 4, 1, 1, 1, 1};
      for (int n = 0; n < 8; n++) begin
         run_op(0, t_op[n], t_a[n], t_b[n], lat, con, res, er);
         checks++;
         if (lat != t_lat[n]) begin
            errors++;
            $display("FAIL directed_latency case=%0d got %0d want %0d", n, lat, t_lat[n]);
         end
         checks++;
         if (con !== t_con[n] || res !== t_res[n] || er !== 1'b0) begin
            errors++;
            $display("FAIL directed_result case=%0d got con=%b res=%h err=%b want con=%b res=%h err=0",
                     n, con, res, er, t_con[n], t_res[n]);
         end
      end
   endtask

   task automatic test_backpressure;
      int n;
      @(negedge clk);
      in_op[0] = 5'd4; dat1[0] = 32'd5; dat2[0] = 32'd9; in_valid[0] = 1'b1;
      @(negedge clk);
      in_valid[0] = 1'b0;
      n = 0;
      while (!out_valid[0] && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (n != 4) begin
         errors++;
         $display("FAIL bp_latency got %0d want 4", n);
      end
      // A competing request while the result is held must be ignored.
      in_op[0] = 5'd12; dat1[0] = 32'd3; dat2[0] = 32'd7; in_valid[0] = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || con_met[0] !== 1'b1 ||
             result[0] !== 32'd0 || err[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold got v=%b rdy=%b c=%b r=%h e=%b want v=1 rdy=0 c=1 r=0 e=0",
                     out_valid[0], in_ready[0], con_met[0], result[0], err[0]);
         end
      end
      out_ready[0] = 1'b1;
      @(negedge clk);
      out_ready[0] = 1'b0;
      checks++;
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL bp_release got v=%b rdy=%b want v=0 rdy=1", out_valid[0], in_ready[0]);
      end
      @(negedge clk);
      checks++;
      if (in_ready[0] !== 1'b0) begin
         errors++;
         $display("FAIL bp_reaccept got in_ready=%b want 0", in_ready[0]);
      end
      in_valid[0] = 1'b0;
      n = 0;
      while (!out_valid[0] && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (n != 4 || result[0] !== 32'd7 || con_met[0] !== 1'b0) begin
         errors++;
         $display("FAIL bp_second_op got lat=%0d res=%h con=%b want lat=4 res=00000007 con=0",
                  n, result[0], con_met[0]);
      end
      out_ready[0] = 1'b1;
      @(negedge clk);
      out_ready[0] = 1'b0;
   endtask

   task automatic test_reset_midrun;
      int          lat;
      logic        con, er;
      logic [31:0] res;
      @(negedge clk);
      in_op[0] = 5'd0; dat1[0] = 32'hA5A5A5A5; dat2[0] = 32'hA5A5A5A5; in_valid[0] = 1'b1;
      @(negedge clk);
      in_valid[0] = 1'b0;
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checks++;
      if (out_valid[0] !== 1'b0 || con_met[0] !== 1'b0 || result[0] !== 32'd0 ||
          err[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL midrun_reset got v=%b c=%b r=%h e=%b rdy=%b want 0 0 0 0 1",
                  out_valid[0], con_met[0], result[0], err[0], in_ready[0]);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (out_valid[0] !== 1'b0) begin
         errors++;
         $display("FAIL midrun_discard got out_valid=%b want 0", out_valid[0]);
      end
      run_op(0, 5'd7, 32'h1234, 32'h1234, lat, con, res, er);
      checks++;
      if (lat != 1 || er !== 1'b1 || con !== 1'b0 || res !== 32'd0) begin
         errors++;
         $display("FAIL illegal_op got lat=%0d err=%b con=%b res=%h want lat=1 err=1 con=0 res=0",
                  lat, er, con, res);
      end
   endtask

   task automatic test_random;
      logic [4:0]  ops[12];
      logic [4:0]  op;
      logic [31:0] a, b;
      int          lat, e_lat, mode;
      logic        con, er, e_con, e_er;
      logic [31:0] res, e_res;
      ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
      for (int i = 0; i < NI; i++) begin
         for (int n = 0; n < 40; n++) begin
            if ($urandom_range(9, 0) == 0)
               op = 5'($urandom_range(31, 15));
            else
               op = ops[$urandom_range(11, 0)];
            a = $urandom;
            mode = $urandom_range(3, 0);
            case (mode)
               0: b = $urandom;
               1: b = a;
               2: b = a ^ (32'd1 << $urandom_range(31, 0));
               default: b = a ^ 32'h80000000;
            endcase
            model(CH[i], op, a, b, e_con, e_res, e_er, e_lat);
            run_op(i, op, a, b, lat, con, res, er);
            checks++;
            if (lat != e_lat || con !== e_con || res !== e_res || er !== e_er) begin
               errors++;
               $display("FAIL random chunk=%0d op=%0d a=%h b=%h got lat=%0d con=%b res=%h err=%b want lat=%0d con=%b res=%h err=%b",
                        CH[i], op, a, b, lat, con, res, er, e_lat, e_con, e_res, e_er);
            end
         end
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_backpressure;
      test_reset_midrun;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
